// File: rtl/prod_accum_pkg.sv
// ============================================================================
// prod_accum_pkg - shared state encoding, default widths and count-width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package prod_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int unsigned c_DEF_PROD_W    = 16;
  localparam int unsigned c_DEF_ACC_W     = 24;
  localparam int unsigned c_DEF_MAX_BEATS = 256;

  // Width needed to hold every count from 0 up to and including max_beats.
  function automatic int unsigned cnt_width(input int unsigned max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/prod_accum_acc_add.sv
// ============================================================================
// acc_add - ACC_W accumulator adder with carry-out; saturates when ACC_SAT_EN is defined
// Rev 1.0
// ============================================================================
`default_nettype none

module acc_add #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] full_sum;

  assign full_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
  assign carry_o  = full_sum[ACC_W];

`ifdef ACC_SAT_EN
  // Once pinned at all-ones, any non-zero product carries again, so the value sticks.
  assign sum_o = carry_o ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
  assign sum_o = full_sum[ACC_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/prod_accum.sv
// ============================================================================
// prod_accum - frames a valid/ready product stream into sum/count/overflow results
// Optional feature: ACC_SAT_EN (saturating accumulator). Rev 1.0
// ============================================================================
`default_nettype none

module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int unsigned PROD_W    = c_DEF_PROD_W,
  parameter int unsigned ACC_W     = c_DEF_ACC_W,
  parameter int unsigned MAX_BEATS = c_DEF_MAX_BEATS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [PROD_W-1:0]                    prod,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ACC_W-1:0]                     out_sum,
  output logic [cnt_width(MAX_BEATS)-1:0]      out_count,
  output logic                                 out_ovf
);

  localparam int unsigned CNT_W = cnt_width(MAX_BEATS);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_valid_q, out_valid_d;

  logic               beat;
  logic               first_beat;
  logic [ACC_W-1:0]   add_base;
  logic [ACC_W-1:0]   add_sum;
  logic               add_carry;
  logic [CNT_W-1:0]   cnt_next;
  logic               ovf_next;
  logic               frame_close;

  assign in_ready   = (state_q != ST_HOLD);
  assign beat       = in_valid && in_ready;
  assign first_beat = (state_q == ST_IDLE);

  // The first beat of a frame loads the product, so the adder sees a zero base.
  assign add_base = first_beat ? '0 : acc_q;

  acc_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_acc_add (
    .acc_i   (add_base),
    .prod_i  (prod),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  assign cnt_next    = first_beat ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign ovf_next    = first_beat ? add_carry : (ovf_q | add_carry);
  assign frame_close = in_last || (cnt_next == CNT_W'(MAX_BEATS));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (beat) begin
          acc_d = add_sum;
          cnt_d = cnt_next;
          ovf_d = ovf_next;
          if (frame_close) begin
            out_sum_d   = add_sum;
            out_count_d = cnt_next;
            out_ovf_d   = ovf_next;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_HOLD: begin
        // Result registers keep their value; only out_valid drops on handshake.
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_prod_accum.sv
// ============================================================================
// tb_prod_accum - directed bench: default-width instance plus a 16-bit/4-beat instance
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_prod_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance 0: default parameters (PROD_W=16, ACC_W=24, MAX_BEATS=256)
  logic        v0, l0, r0;
  logic [15:0] p0;
  logic        rdy0, ov0, ovf0;
  logic [23:0] s0;
  logic [8:0]  c0;

  // Instance 1: ACC_W=16, MAX_BEATS=4
  logic        v1, l1, r1;
  logic [15:0] p1;
  logic        rdy1, ov1, ovf1;
  logic [15:0] s1;
  logic [2:0]  c1;

  prod_accum u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v0),
    .in_ready  (rdy0),
    .prod      (p0),
    .in_last   (l0),
    .out_valid (ov0),
    .out_ready (r0),
    .out_sum   (s0),
    .out_count (c0),
    .out_ovf   (ovf0)
  );

  prod_accum #(
    .PROD_W    (16),
    .ACC_W     (16),
    .MAX_BEATS (4)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1),
    .in_ready  (rdy1),
    .prod      (p1),
    .in_last   (l1),
    .out_valid (ov1),
    .out_ready (r1),
    .out_sum   (s1),
    .out_count (c1),
    .out_ovf   (ovf1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic send(input int k, input logic [15:0] p, input logic last);
    @(negedge clk);
    if (k == 0) begin v0 = 1'b1; p0 = p; l0 = last; end
    else        begin v1 = 1'b1; p1 = p; l1 = last; end
    @(posedge clk);
    #1;
    v0 = 1'b0; l0 = 1'b0;
    v1 = 1'b0; l1 = 1'b0;
  endtask

  task automatic expect_res(input int k, input string tag, input logic [31:0] sum,
                            input logic [31:0] cnt, input logic ovf);
    @(negedge clk);
    if (k == 0) begin
      check({tag, ".valid"}, 32'(ov0), 32'd1);
      check({tag, ".sum"},   32'(s0),  sum);
      check({tag, ".count"}, 32'(c0),  cnt);
      check({tag, ".ovf"},   32'(ovf0), 32'(ovf));
      check({tag, ".in_ready"}, 32'(rdy0), 32'd0);
    end else begin
      check({tag, ".valid"}, 32'(ov1), 32'd1);
      check({tag, ".sum"},   32'(s1),  sum);
      check({tag, ".count"}, 32'(c1),  cnt);
      check({tag, ".ovf"},   32'(ovf1), 32'(ovf));
      check({tag, ".in_ready"}, 32'(rdy1), 32'd0);
    end
  endtask

  task automatic drain(input int k, input string tag);
    @(negedge clk);
    if (k == 0) r0 = 1'b1; else r1 = 1'b1;
    @(posedge clk);
    #1;
    r0 = 1'b0; r1 = 1'b0;
    @(negedge clk);
    if (k == 0) begin
      check({tag, ".drain_valid"}, 32'(ov0), 32'd0);
      check({tag, ".drain_ready"}, 32'(rdy0), 32'd1);
    end else begin
      check({tag, ".drain_valid"}, 32'(ov1), 32'd0);
      check({tag, ".drain_ready"}, 32'(rdy1), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v0 = 0; l0 = 0; r0 = 0; p0 = '0;
    v1 = 0; l1 = 0; r1 = 0; p1 = '0;

    // Reset state
    #12;
    check("rst.valid0", 32'(ov0), 32'd0);
    check("rst.sum0",   32'(s0),  32'd0);
    check("rst.count0", 32'(c0),  32'd0);
    check("rst.ovf0",   32'(ovf0), 32'd0);
    check("rst.ready0", 32'(rdy0), 32'd1);
    check("rst.ready1", 32'(rdy1), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while instance 0 is mid-frame and instance 1 holds a result
    send(0, 16'd500, 1'b0);
    send(1, 16'd500, 1'b1);
    @(negedge clk);
    check("pre_rst.valid0", 32'(ov0), 32'd0);
    check("pre_rst.valid1", 32'(ov1), 32'd1);
    check("pre_rst.ready1", 32'(rdy1), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.valid1", 32'(ov1), 32'd0);
    check("async_rst.sum1",   32'(s1),  32'd0);
    check("async_rst.count1", 32'(c1),  32'd0);
    check("async_rst.ready1", 32'(rdy1), 32'd1);
    check("async_rst.ready0", 32'(rdy0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Two-beat frame; a stale 500 would show up in the sum
    send(0, 16'd140, 1'b0);
    send(0, 16'd2460, 1'b1);
    expect_res(0, "two_beat", 32'd2600, 32'd2, 1'b0);
    drain(0, "two_beat");

    // Single-beat frame, result one cycle after acceptance
    send(0, 16'd65535, 1'b1);
    expect_res(0, "single", 32'd65535, 32'd1, 1'b0);
    drain(0, "single");

    // Backpressure with a pending product held on the input
    send(0, 16'd300, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin v0 = 1'b1; p0 = 16'd7; l0 = 1'b1; end
      check("bp.valid", 32'(ov0), 32'd1);
      check("bp.sum",   32'(s0),  32'd300);
      check("bp.ready", 32'(rdy0), 32'd0);
    end
    @(negedge clk);
    r0 = 1'b1;
    @(posedge clk);
    #1;
    r0 = 1'b0;
    @(negedge clk);
    check("bp.after_valid", 32'(ov0), 32'd0);
    check("bp.after_ready", 32'(rdy0), 32'd1);
    @(posedge clk);
    #1;
    v0 = 1'b0; l0 = 1'b0;
    expect_res(0, "bp_held", 32'd7, 32'd1, 1'b0);
    drain(0, "bp_held");

    // 65535+1 fits in 24 bits
    send(0, 16'd65535, 1'b0);
    send(0, 16'd1, 1'b1);
    expect_res(0, "wide_no_ovf", 32'd65536, 32'd2, 1'b0);
    drain(0, "wide_no_ovf");

    // 65535+1 overflows a 16-bit accumulator
    send(1, 16'd65535, 1'b0);
    send(1, 16'd1, 1'b1);
`ifdef ACC_SAT_EN
    expect_res(1, "ovf16", 32'd65535, 32'd2, 1'b1);
`else
    expect_res(1, "ovf16", 32'd0, 32'd2, 1'b1);
`endif
    drain(1, "ovf16");

    // Overflow flag does not leak into the next frame
    send(1, 16'd3, 1'b0);
    send(1, 16'd4, 1'b1);
    expect_res(1, "post_ovf", 32'd7, 32'd2, 1'b0);
    drain(1, "post_ovf");

    // Force close on beat MAX_BEATS=4 without in_last
    for (int i = 0; i < 3; i++) send(1, 16'd10, 1'b0);
    @(negedge clk);
    check("force.three_beats_open", 32'(ov1), 32'd0);
    send(1, 16'd10, 1'b0);
    expect_res(1, "force", 32'd40, 32'd4, 1'b0);
    drain(1, "force");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
